// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong broadcast path: coordinate width, packet
// framing constants, the packetizer state enum and a small byte-split helper.
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         PKT_LEN           = 9;
  localparam int         COORD_W           = 11;

  // Everything after SYNC and SEQ and before CSUM is coordinate payload.
  localparam int         FIELD_BYTES       = PKT_LEN - 3;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    FIELD,
    CSUM
  } pkt_state_t;

  // Coordinates travel as two bytes: the high byte is zero-padded to 8 bits.
  function automatic logic [7:0] coord_byte(input logic [COORD_W-1:0] coord,
                                            input logic hi);
    return hi ? {5'b0, coord[10:8]} : coord[7:0];
  endfunction

endpackage

// File: rtl/xor_checksum.sv
// ---------------------------------------------------------------------------
// xor_checksum
// 8-bit running XOR accumulator used for the packet checksum.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : zero the accumulator (start of a packet)
//   enable         : fold data into the accumulator (accepted payload byte)
//   data           : byte to accumulate
//   sum            : registered running checksum
// ---------------------------------------------------------------------------
module xor_checksum (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  // Clear wins over enable so a new packet always starts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/state_packetizer.sv
// ---------------------------------------------------------------------------
// state_packetizer
// Serializes ball x/y and opponent paddle y into a 9-byte framed packet
// (sync, seq, six coordinate bytes, XOR checksum) over a valid/ready link.
// One request can wait while a packet is in flight; extra ones are counted.
// Ports:
//   clock, reset_n        : system clock, asynchronous active-low reset
//   send_tick             : single-cycle packet request
//   ball_x, ball_y, opp_y : coordinates, sampled when a packet starts
//   tx_data, tx_valid     : current byte and its valid flag
//   tx_ready              : downstream accepts on tx_valid && tx_ready
//   busy                  : packet in progress or request pending
//   overrun_cnt           : saturating count of dropped requests
// ---------------------------------------------------------------------------
module state_packetizer
  import pong_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         OVR_W     = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               send_tick,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] opp_y,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [OVR_W-1:0]   overrun_cnt
);

  pkt_state_t         state, state_next;
  logic [2:0]         field_idx, field_idx_next;
  logic [7:0]         seq;
  logic               pending;
  logic [COORD_W-1:0] snap_bx, snap_by, snap_oy;
  logic               handshake;
  logic               start_pkt;
  logic               csum_en;
  logic [7:0]         csum;

  assign tx_valid  = (state != IDLE);
  assign handshake = tx_valid && tx_ready;
  assign busy      = (state != IDLE) || pending;

  // Checksum covers seq through opp_y low byte; it is folded in as each of
  // those bytes is accepted, so it is already registered when CSUM shows.
  xor_checksum u_csum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_pkt),
    .enable  (csum_en),
    .data    (tx_data),
    .sum     (csum)
  );

  // State and payload byte index advance only on an accepted byte, which
  // keeps tx_valid/tx_data stable while the downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      field_idx <= 3'd0;
    end else begin
      state     <= state_next;
      field_idx <= field_idx_next;
    end
  end

  // Next-state logic. A packet starts from IDLE on a tick, or straight out
  // of CSUM when a request is waiting (including one arriving on the very
  // cycle the checksum is accepted), giving back-to-back packets.
  always_comb begin
    state_next     = state;
    field_idx_next = field_idx;
    start_pkt      = 1'b0;
    csum_en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_tick || pending) begin
          state_next = SYNC;
          start_pkt  = 1'b1;
        end
      end
      SYNC: begin
        if (handshake) state_next = SEQ;
      end
      SEQ: begin
        if (handshake) begin
          state_next     = FIELD;
          field_idx_next = 3'd0;
          csum_en        = 1'b1;
        end
      end
      FIELD: begin
        if (handshake) begin
          csum_en = 1'b1;
          if (field_idx == 3'(FIELD_BYTES - 1)) begin
            state_next = CSUM;
          end else begin
            field_idx_next = field_idx + 3'd1;
          end
        end
      end
      CSUM: begin
        if (handshake) begin
          if (pending || send_tick) begin
            state_next = SYNC;
            start_pkt  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output byte is a pure mux of registered state, so tx_ready never has a
  // combinational path to tx_data.
  always_comb begin
    tx_data = 8'h00;
    unique case (state)
      SYNC:  tx_data = SYNC_BYTE;
      SEQ:   tx_data = seq;
      FIELD: begin
        unique case (field_idx)
          3'd0:    tx_data = coord_byte(snap_bx, 1'b1);
          3'd1:    tx_data = coord_byte(snap_bx, 1'b0);
          3'd2:    tx_data = coord_byte(snap_by, 1'b1);
          3'd3:    tx_data = coord_byte(snap_by, 1'b0);
          3'd4:    tx_data = coord_byte(snap_oy, 1'b1);
          3'd5:    tx_data = coord_byte(snap_oy, 1'b0);
          default: tx_data = 8'h00;
        endcase
      end
      CSUM:    tx_data = csum;
      default: tx_data = 8'h00;
    endcase
  end

  // Coordinates are frozen at packet start so mid-packet updates from the
  // game server cannot tear a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_bx <= '0;
      snap_by <= '0;
      snap_oy <= '0;
    end else if (start_pkt) begin
      snap_bx <= ball_x;
      snap_by <= ball_y;
      snap_oy <= opp_y;
    end
  end

  // Sequence number moves on only once the whole packet has gone out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq <= 8'h00;
    end else if ((state == CSUM) && handshake) begin
      seq <= seq + 8'd1;
    end
  end

  // One-deep request queue plus a saturating counter for requests that
  // arrive when the queue slot is already taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (start_pkt) begin
        pending <= 1'b0;
      end else if (send_tick && (state != IDLE)) begin
        pending <= 1'b1;
      end
      if (send_tick && pending && !(&overrun_cnt)) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_state_packetizer.sv
// ---------------------------------------------------------------------------
// tb_state_packetizer
// Self-checking bench: expected bytes are queued when a tick is driven and
// compared as the DUT hands each byte off; hand sequences cover timing.
// ---------------------------------------------------------------------------
module tb_state_packetizer;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        send_tick = 1'b0;
  logic        tx_ready  = 1'b1;
  logic [10:0] ball_x    = 11'd0;
  logic [10:0] ball_y    = 11'd0;
  logic [10:0] opp_y     = 11'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  model_seq  = 8'h00;
  logic [7:0]  model_ovr  = 8'h00;

  typedef struct {
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] oy;
    logic [7:0]  fx;
  } vec_t;

  vec_t vecs[5];

  state_packetizer #(.SYNC_BYTE(8'hA5), .OVR_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .send_tick   (send_tick),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .opp_y       (opp_y),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  // 10 ns clock period.
  always #5 clock = ~clock;

  // Hard stop in case the design never settles.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] fieldXor(input logic [10:0] bx,
                                          input logic [10:0] by,
                                          input logic [10:0] oy);
    return {5'b0, bx[10:8]} ^ bx[7:0] ^ {5'b0, by[10:8]} ^ by[7:0] ^
           {5'b0, oy[10:8]} ^ oy[7:0];
  endfunction

  task automatic pushPacket(input logic [10:0] bx, input logic [10:0] by,
                            input logic [10:0] oy, input logic [7:0] fx);
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    exp_q.push_back({5'b0, bx[10:8]});
    exp_q.push_back(bx[7:0]);
    exp_q.push_back({5'b0, by[10:8]});
    exp_q.push_back(by[7:0]);
    exp_q.push_back({5'b0, oy[10:8]});
    exp_q.push_back(oy[7:0]);
    exp_q.push_back(model_seq ^ fx);
    model_seq = model_seq + 8'd1;
  endtask

  // Pulse send_tick for one cycle with the given coordinates. expect_pkt
  // says whether this tick produces a packet or only bumps the overrun
  // count. Returns one cycle after the tick (cycle t+1).
  task automatic applyStimulus(input logic [10:0] bx, input logic [10:0] by,
                               input logic [10:0] oy, input bit expect_pkt,
                               input logic [7:0] fx);
    ball_x    = bx;
    ball_y    = by;
    opp_y     = oy;
    send_tick = 1'b1;
    if (expect_pkt) pushPacket(bx, by, oy, fx);
    else if (model_ovr != 8'hFF) model_ovr = model_ovr + 8'd1;
    step(1);
    send_tick = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      step(1);
      n++;
    end
    checkOutput({name, "_drained"}, (n < max_cycles) ? 1 : 0, 1);
    checkOutput({name, "_idle_valid"}, tx_valid, 0);
  endtask

  // Scoreboard: every accepted byte is popped and compared. Sampled on the
  // falling edge, where tx_valid/tx_ready describe the coming rising edge.
  always @(negedge clock) begin
    if (reset_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        checkOutput("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{bx: 11'd500,   by: 11'd500,   oy: 11'd300,   fx: 8'h2D};
    vecs[1] = '{bx: 11'd0,     by: 11'd0,     oy: 11'd0,     fx: 8'h00};
    vecs[2] = '{bx: 11'h7FF,   by: 11'h7FF,   oy: 11'h7FF,   fx: 8'hF8};
    vecs[3] = '{bx: 11'h123,   by: 11'h456,   oy: 11'h789,   fx: 8'hFE};
    vecs[4] = '{bx: 11'h555,   by: 11'h2AA,   oy: 11'h100,   fx: 8'hF9};

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun_cnt, 0);
    reset_n = 1'b1;
    step(2);

    // Single packet with exact cycle timing
    $display("[TB] single packet");
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    checkOutput("t1_sync_valid", tx_valid, 1);
    checkOutput("t1_sync_data", tx_data, 8'hA5);
    step(8);
    checkOutput("t1_csum_valid", tx_valid, 1);
    checkOutput("t1_csum_data", tx_data, 8'h2D);
    step(1);
    checkOutput("t1_after_valid", tx_valid, 0);
    checkOutput("t1_after_busy", busy, 0);
    step(1);

    // Backpressure on the third byte
    $display("[TB] backpressure");
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    step(2);
    checkOutput("bp_byte3", tx_data, 8'h01);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("bp_hold_valid", tx_valid, 1);
      checkOutput("bp_hold_data", tx_data, 8'h01);
    end
    tx_ready = 1'b1;
    waitDrain(40, "bp");

    // Snapshot: input change after the tick must not reach the packet
    $display("[TB] snapshot");
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    step(1);
    ball_x = 11'd900;
    waitDrain(40, "snap");

    // Overrun: one pending request, two dropped
    $display("[TB] overrun");
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    step(2);
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    step(1);
    applyStimulus(11'd500, 11'd500, 11'd300, 0, 8'h00);
    step(1);
    applyStimulus(11'd500, 11'd500, 11'd300, 0, 8'h00);
    step(1);
    checkOutput("ovr_busy", busy, 1);
    step(1);
    checkOutput("ovr_b2b_valid", tx_valid, 1);
    checkOutput("ovr_b2b_sync", tx_data, 8'hA5);
    waitDrain(60, "ovr");
    checkOutput("ovr_count", overrun_cnt, model_ovr);

    // Tick on the same cycle as the checksum handshake
    $display("[TB] tick at csum");
    applyStimulus(11'd77, 11'd1000, 11'd2000, 1, fieldXor(11'd77, 11'd1000, 11'd2000));
    step(8);
    applyStimulus(11'd77, 11'd1000, 11'd2000, 1, fieldXor(11'd77, 11'd1000, 11'd2000));
    checkOutput("csumtick_valid", tx_valid, 1);
    checkOutput("csumtick_sync", tx_data, 8'hA5);
    waitDrain(60, "csumtick");
    checkOutput("csumtick_ovr", overrun_cnt, model_ovr);

    // Table-driven coordinate vectors with hand-computed field XORs
    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].bx, vecs[i].by, vecs[i].oy, 1, vecs[i].fx);
      waitDrain(40, "table");
    end

    // Reset in the middle of a packet
    $display("[TB] reset mid-packet");
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    step(4);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", tx_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_data", tx_data, 8'h00);
    checkOutput("mid_rst_ovr", overrun_cnt, 0);
    exp_q.delete();
    model_seq = 8'h00;
    model_ovr = 8'h00;
    step(1);
    reset_n = 1'b1;
    step(1);
    applyStimulus(11'd500, 11'd500, 11'd300, 1, fieldXor(11'd500, 11'd500, 11'd300));
    checkOutput("post_rst_sync", tx_data, 8'hA5);
    step(1);
    checkOutput("post_rst_seq", tx_data, 8'h00);
    waitDrain(40, "post_rst");

    // Sequence wrap: enough packets for seq to roll over 255 -> 0
    $display("[TB] seq wrap");
    for (int i = 0; i < 257; i++) begin
      logic [10:0] rx, ry, ro;
      rx = 11'($urandom_range(0, 2047));
      ry = 11'($urandom_range(0, 2047));
      ro = 11'($urandom_range(0, 2047));
      applyStimulus(rx, ry, ro, 1, fieldXor(rx, ry, ro));
      waitDrain(40, "wrap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
